// File: rtl/sync_fifo_param_pkg.sv
// rtl/sync_fifo_param_pkg.sv - shared FIFO helpers: clog2 and sticky error bit indices
package sync_fifo_param_pkg;

    localparam int ERR_OVF  = 0;
    localparam int ERR_UNF  = 1;
    localparam int ERR_BITS = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// rtl/fifo_mem_1r1w.sv - 1W/1R storage array, synchronous write, asynchronous read
module fifo_mem_1r1w
    import sync_fifo_param_pkg::*;
#(
    parameter  int DWIDTH = 8,
    parameter  int DEPTH  = 16,
    localparam int AWIDTH = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO, any depth, level flags, sticky errors, flush
// SYNC_FIFO_FWFT_EN selects first-word-fall-through reads; default is registered read.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter  int DWIDTH   = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = 12,
    parameter  int AE_LEVEL = 4,
    localparam int CWIDTH   = clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic              o_full,
    output logic              o_almost_full,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_empty,
    output logic              o_almost_empty,
    output logic [CWIDTH-1:0] o_count,
    output logic              o_overflow,
    output logic              o_underflow,
    input  logic              i_clr_err
);

    localparam int PW = clog2(DEPTH);

    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CWIDTH-1:0]   r_count;
    logic [CWIDTH-1:0]   w_count_nxt;
    logic                r_full;
    logic                r_empty;
    logic                r_af;
    logic                r_ae;
    logic [ERR_BITS-1:0] r_err;
    logic [ERR_BITS-1:0] w_err_nxt;
    logic                w_push_ok;
    logic                w_pop_ok;
    logic [DWIDTH-1:0]   w_mem_rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_push_ok   = i_push & ~r_full;
    assign w_pop_ok    = i_pop & ~r_empty;
    assign w_count_nxt = r_count + CWIDTH'(w_push_ok) - CWIDTH'(w_pop_ok);

    always_comb begin
        w_err_nxt          = r_err & ~{ERR_BITS{i_clr_err}};
        w_err_nxt[ERR_OVF] = w_err_nxt[ERR_OVF] | (i_push & r_full);
        w_err_nxt[ERR_UNF] = w_err_nxt[ERR_UNF] | (i_pop & r_empty);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_err    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_err    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CWIDTH'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= CWIDTH'(AF_LEVEL));
            r_ae    <= (w_count_nxt <= CWIDTH'(AE_LEVEL));
            r_err   <= w_err_nxt;
        end
    end

    fifo_mem_1r1w #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push_ok & ~i_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; zero while empty so reset shows rdata=0.
    assign o_rdata  = r_empty ? '0 : w_mem_rdata;
    assign o_rvalid = ~r_empty;
`else
    logic [DWIDTH-1:0] r_rdata;
    logic              r_rvalid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (i_flush) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_pop_ok;
            if (w_pop_ok) begin
                r_rdata <= w_mem_rdata;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_af;
    assign o_almost_empty = r_ae;
    assign o_count        = r_count;
    assign o_overflow     = r_err[ERR_OVF];
    assign o_underflow    = r_err[ERR_UNF];

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param at DEPTH=16 and DEPTH=5
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_flush = 0, a_push = 0, a_pop = 0, a_clr = 0;
    logic [7:0] a_wdata = 0, a_rdata;
    logic       a_full, a_af, a_rvalid, a_empty, a_ae, a_ovf, a_unf;
    logic [4:0] a_count;

    logic       b_flush = 0, b_push = 0, b_pop = 0, b_clr = 0;
    logic [7:0] b_wdata = 0, b_rdata;
    logic       b_full, b_af, b_rvalid, b_empty, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;

    sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) u_a (
        .i_clk(clk), .i_reset(rst), .i_flush(a_flush), .i_push(a_push), .i_wdata(a_wdata),
        .o_full(a_full), .o_almost_full(a_af), .i_pop(a_pop), .o_rdata(a_rdata),
        .o_rvalid(a_rvalid), .o_empty(a_empty), .o_almost_empty(a_ae), .o_count(a_count),
        .o_overflow(a_ovf), .o_underflow(a_unf), .i_clr_err(a_clr)
    );

    sync_fifo_param #(.DWIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_flush(b_flush), .i_push(b_push), .i_wdata(b_wdata),
        .o_full(b_full), .o_almost_full(b_af), .i_pop(b_pop), .o_rdata(b_rdata),
        .o_rvalid(b_rvalid), .o_empty(b_empty), .o_almost_empty(b_ae), .o_count(b_count),
        .o_overflow(b_ovf), .o_underflow(b_unf), .i_clr_err(b_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && a_rvalid && (!FWFT || a_pop)) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rvalid", {24'h0, a_rdata}, 32'hFFFF_FFFF);
            end else begin
                ea = qa.pop_front();
                chk("a_rdata", {24'h0, a_rdata}, {24'h0, ea});
            end
        end
        if (!rst && b_rvalid && (!FWFT || b_pop)) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rvalid", {24'h0, b_rdata}, 32'hFFFF_FFFF);
            end else begin
                eb = qb.pop_front();
                chk("b_rdata", {24'h0, b_rdata}, {24'h0, eb});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_af", a_af, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_errs", {a_ovf, a_unf}, 0);

        // fill to full, then one push too many
        for (int i = 0; i < 16; i++) begin
            a_push = 1; a_wdata = 8'(i);
            tick();
            chk("fill_count", a_count, i + 1);
            chk("fill_af", a_af, (i + 1 >= 12));
            chk("fill_full", a_full, (i + 1 == 16));
        end
        a_wdata = 8'hFF;
        tick();
        a_push = 0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_count", a_count, 16);
        chk("ovf_full", a_full, 1);

        // drain in order, then one pop too many
        for (int i = 0; i < 16; i++) begin
            a_pop = 1; qa.push_back(8'(i));
            tick();
            chk("drain_count", a_count, 15 - i);
        end
        tick();
        a_pop = 0;
        chk("unf_set", a_unf, 1);
        chk("unf_rvalid", a_rvalid, 0);
        chk("unf_empty", a_empty, 1);
        chk("ovf_sticky", a_ovf, 1);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("clr_err", {a_ovf, a_unf}, 0);

        // simultaneous push+pop at count 3, at full, at empty
        for (int i = 0; i < 3; i++) begin
            a_push = 1; a_wdata = 8'h10 + 8'(i);
            tick();
        end
        a_pop = 1; a_wdata = 8'h13; qa.push_back(8'h10);
        tick();
        a_pop = 0;
        chk("pp3_count", a_count, 3);
        for (int i = 0; i < 13; i++) begin
            a_wdata = 8'h14 + 8'(i);
            tick();
        end
        chk("pp_full", a_full, 1);
        a_pop = 1; a_wdata = 8'h99; qa.push_back(8'h11);
        tick();
        a_push = 0;
        chk("ppfull_ovf", a_ovf, 1);
        chk("ppfull_count", a_count, 15);
        for (int i = 0; i < 15; i++) begin
            qa.push_back(8'h12 + 8'(i));
            tick();
        end
        a_pop = 0;
        chk("pp_drained", a_empty, 1);
        a_push = 1; a_pop = 1; a_wdata = 8'h55;
        tick();
        a_push = 0; a_pop = 0;
        chk("ppempty_count", a_count, 1);
        chk("ppempty_unf", a_unf, 1);

        // flush at count 7 with push high
        a_push = 1;
        for (int i = 0; i < 6; i++) begin
            a_wdata = 8'h56 + 8'(i);
            tick();
        end
        chk("pre_flush_count", a_count, 7);
        a_flush = 1; a_wdata = 8'hEE;
        tick();
        a_flush = 0; a_push = 0;
        chk("flush_count", a_count, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ae", a_ae, 1);
        chk("flush_errs", {a_ovf, a_unf}, 0);
        chk("flush_rvalid", a_rvalid, 0);
        a_push = 1; a_wdata = 8'h77;
        tick();
        a_push = 0; a_pop = 1; qa.push_back(8'h77);
        tick();
        a_pop = 0;
        tick();
        chk("post_flush_empty", a_empty, 1);

        // asynchronous reset mid-stream
        a_push = 1; a_wdata = 8'h31;
        tick();
        a_wdata = 8'h32;
        tick();
        a_push = 0;
        rst = 1;
        #1;
        chk("arst_count", a_count, 0);
        chk("arst_empty", a_empty, 1);
        chk("arst_ae", a_ae, 1);
        chk("arst_rdata", a_rdata, 0);
        chk("arst_rvalid", a_rvalid, 0);
        rst = 0;
        tick();

`ifdef SYNC_FIFO_FWFT_EN
        a_push = 1; a_wdata = 8'hA5;
        tick();
        a_push = 0;
        chk("fwft_rdata", a_rdata, 8'hA5);
        chk("fwft_rvalid", a_rvalid, 1);
        a_pop = 1; qa.push_back(8'hA5);
        tick();
        a_pop = 0;
        chk("fwft_pop_rvalid", a_rvalid, 0);
`endif

        // DEPTH=5: fill, overflow, then wrap pointers with interleaved push/pop
        for (int i = 0; i < 5; i++) begin
            b_push = 1; b_wdata = 8'hA0 + 8'(i);
            tick();
            chk("b_fill_count", b_count, i + 1);
            chk("b_fill_af", b_af, (i + 1 >= 4));
        end
        chk("b_full", b_full, 1);
        b_wdata = 8'hFF;
        tick();
        b_push = 0;
        chk("b_ovf", b_ovf, 1);
        b_clr = 1;
        tick();
        b_clr = 0;
        b_pop = 1;
        qb.push_back(8'hA0); tick();
        qb.push_back(8'hA1); tick();
        b_pop = 0;
        chk("b_count3", b_count, 3);
        for (int k = 0; k < 12; k++) begin
            b_push = 1; b_pop = 1; b_wdata = 8'hB0 + 8'(k);
            qb.push_back((k < 3) ? 8'hA2 + 8'(k) : 8'hB0 + 8'(k - 3));
            tick();
            chk("b_wrap_count", b_count, 3);
        end
        b_push = 0;
        for (int j = 0; j < 3; j++) begin
            qb.push_back(8'hB9 + 8'(j));
            tick();
        end
        b_pop = 0;
        tick();
        chk("b_empty", b_empty, 1);
        chk("b_ae", b_ae, 1);
        chk("b_errs", {b_ovf, b_unf}, 0);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
